// File: rtl/div_pkg.sv
// Shared types and defaults for the iterative restoring divider.
package div_pkg;

    localparam int unsigned DIV_N = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {r,q} left, trial-subtract d, keep or restore.
module div_step #(
    parameter int unsigned N = 8
) (
    input  logic [N:0]     r,
    input  logic [2*N-1:0] q,
    input  logic [N-1:0]   d,
    output logic [N:0]     r_next,
    output logic [2*N-1:0] q_next
);

    logic [N:0] r_shift;
    logic [N:0] op2;
    logic [N:0] trial;
    logic [N+1:0] carry;

    assign r_shift = {r[N-1:0], q[2*N-1]};
    assign op2     = ~{1'b0, d};

    // Ripple-carry add of the inverted divisor with carry-in 1 forms r_shift - d mod 2^(N+1).
    assign carry[0] = 1'b1;
    genvar i;
    generate
        for (i = 0; i <= N; i++) begin : g_rca
            assign trial[i]   = r_shift[i] ^ op2[i] ^ carry[i];
            assign carry[i+1] = (r_shift[i] & op2[i]) | (carry[i] & (r_shift[i] ^ op2[i]));
        end
    endgenerate

    // A clear MSB means the trial difference is non-negative.
    assign r_next = trial[N] ? r_shift : trial;
    assign q_next = {q[2*N-2:0], ~trial[N]};

    logic unused_carry;
    assign unused_carry = carry[N+1];

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring unsigned divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
module seq_divider
    import div_pkg::*;
#(
    parameter int unsigned N = DIV_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           dbz
);

    localparam int unsigned QW = 2 * N;
    localparam int unsigned CW = $clog2(QW);

    state_t         state;
    logic [N:0]     r;
    logic [QW-1:0]  q;
    logic [N-1:0]   d;
    logic [CW-1:0]  count;
    logic [N:0]     r_next;
    logic [QW-1:0]  q_next;

    div_step #(.N(N)) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            dbz   <= 1'b0;
            r     <= '0;
            q     <= '0;
            d     <= '0;
            count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (divisor != '0) begin
                            q     <= dividend;
                            d     <= divisor;
                            r     <= '0;
                            count <= CW'(QW - 1);
                            dbz   <= 1'b0;
                            busy  <= 1'b1;
                            state <= DIVIDE;
                        end else begin
                            // Divide-by-zero skips the iteration and reports all-ones.
                            q     <= '1;
                            r     <= '0;
                            dbz   <= 1'b1;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                DIVIDE: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - CW'(1);
                    if (count == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign quotient  = q;
    assign remainder = r[N-1:0];

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed vectors, handshake corner cases, random vs. arithmetic model.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        dbz;

    int checks = 0;
    int errors = 0;

    seq_divider #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        z;
        int          lat;
        int          busy_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE; return results at the done cycle, then advance so the DUT is IDLE again.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                          output int done_cyc, output int busy_cnt,
                          output logic [15:0] q, output logic [7:0] r, output logic z);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        step();
        start    = 1'b0;
        done_cyc = -1;
        busy_cnt = 0;
        for (int c = 1; c <= 40 && done_cyc < 0; c++) begin
            if (busy) busy_cnt++;
            if (done) done_cyc = c;
            else step();
        end
        q = quotient;
        r = remainder;
        z = dbz;
        step();
    endtask

    initial begin
        int          dc, bc, pulses, first_done, second_done;
        logic [15:0] q, a;
        logic [7:0]  r, b;
        logic        z;

        vecs[0] = '{16'd65025, 8'd255, 16'd255,   8'd0, 1'b0, 17, 16};
        vecs[1] = '{16'd1000,  8'd7,   16'd142,   8'd6, 1'b0, 17, 16};
        vecs[2] = '{16'd65535, 8'd1,   16'd65535, 8'd0, 1'b0, 17, 16};
        vecs[3] = '{16'd5,     8'd200, 16'd0,     8'd5, 1'b0, 17, 16};
        vecs[4] = '{16'd100,   8'd0,   16'hFFFF,  8'd0, 1'b1, 1,  0};
        vecs[5] = '{16'd100,   8'd10,  16'd10,    8'd0, 1'b0, 17, 16};

        reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
        step(); step();
        reset = 1'b0;
        check("reset_outputs", {busy, done, dbz, quotient, remainder}, 0);

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, dc, bc, q, r, z);
            check($sformatf("vec%0d_latency", i), dc, vecs[i].lat);
            check($sformatf("vec%0d_busy_cycles", i), bc, vecs[i].busy_cycles);
            check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
            check($sformatf("vec%0d_hold", i), {quotient, remainder}, {vecs[i].q, vecs[i].r});
        end

        // A start pulse mid-operation must be ignored.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        dc = -1;
        for (int c = 1; c <= 40 && dc < 0; c++) begin
            if (c == 5) begin
                dividend = 16'd50; divisor = 8'd5; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done) dc = c;
            else step();
        end
        start = 1'b0;
        check("ignore_start_latency", dc, 17);
        check("ignore_start_result", {quotient, remainder}, {16'd142, 8'd6});
        step();

        // Reset mid-operation aborts without a done pulse.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        for (int c = 1; c < 8; c++) begin
            if (done) pulses++;
            step();
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_outputs", {busy, done, dbz, quotient, remainder}, 0);
        for (int c = 0; c < 20; c++) begin
            if (done || busy) pulses++;
            step();
        end
        check("abort_no_done", pulses, 0);
        run_op(16'd81, 8'd9, dc, bc, q, r, z);
        check("after_abort_result", {q, r, z}, {16'd9, 8'd0, 1'b0});
        check("after_abort_latency", dc, 17);

        // Start held high: back-to-back operations every 2N+2 cycles.
        dividend = 16'd1000; divisor = 8'd7; start = 1'b1;
        step();
        first_done = -1; second_done = -1;
        for (int c = 1; c <= 60 && second_done < 0; c++) begin
            if (done) begin
                if (first_done < 0) first_done = c;
                else begin
                    second_done = c;
                    start = 1'b0;
                end
            end
            if (second_done < 0) step();
        end
        start = 1'b0;
        check("held_first_done", first_done, 17);
        check("held_second_done", second_done, 35);
        check("held_result", {quotient, remainder}, {16'd142, 8'd6});
        step();

        // Random operands against plain integer division.
        for (int i = 0; i < 2000; i++) begin
            a = 16'($urandom);
            if (i % 4 == 0) a = 16'($urandom_range(0, 600));
            b = 8'($urandom_range(1, 255));
            run_op(a, b, dc, bc, q, r, z);
            check($sformatf("rand%0d_%0d/%0d", i, a, b), {q, r, z, 8'(dc)},
                  {16'(a / b), 8'(a % b), 1'b0, 8'd17});
            checks++;
            if ((int'(q) * int'(b) + int'(r) != int'(a)) || (r >= b)) begin
                errors++;
                $display("FAIL rand%0d_invariant actual q=%0d r=%0d required q*%0d+r=%0d r<%0d",
                         i, q, r, b, a, b);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
